// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key sequencer: FSM states, prefix codes and the
// list of protocol bytes that carry no key information.
package ps2_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_e;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam int unsigned NUM_IGN = 7;
    localparam logic [NUM_IGN-1:0][7:0] IGN_CODES = {
        8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFF, 8'hE1
    };

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_IGN); i++) begin
            if (b == IGN_CODES[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Byte-in / event-out bundle of the PS/2 key sequencer. The master modport is the sequencer,
// the slave modport is the FIFO/consumer side.
interface ps2_key_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_pop;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_scan;
    logic [7:0] evt_ascii;
    logic       evt_release;
    logic       evt_ext;

    modport master (
        input  in_valid, in_data, evt_ready,
        output in_pop, evt_valid, evt_scan, evt_ascii, evt_release, evt_ext
    );

    modport slave (
        output in_valid, in_data, evt_ready,
        input  in_pop, evt_valid, evt_scan, evt_ascii, evt_release, evt_ext
    );
endinterface

// File: rtl/ps2_key_ctrl_scan_ascii.sv
// Scan code set 2 to uppercase ASCII for letters and digits; everything else maps to 0x00.
module scan_ascii (
    input  logic [7:0] scan,
    output logic [7:0] ascii
);
    always_comb begin
        ascii = 8'h00;
        case (scan)
            8'h1C: ascii = 8'h41;  8'h32: ascii = 8'h42;  8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44;  8'h24: ascii = 8'h45;  8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47;  8'h33: ascii = 8'h48;  8'h43: ascii = 8'h49;
            8'h3B: ascii = 8'h4A;  8'h42: ascii = 8'h4B;  8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D;  8'h31: ascii = 8'h4E;  8'h44: ascii = 8'h4F;
            8'h4D: ascii = 8'h50;  8'h15: ascii = 8'h51;  8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53;  8'h2C: ascii = 8'h54;  8'h3C: ascii = 8'h55;
            8'h2A: ascii = 8'h56;  8'h1D: ascii = 8'h57;  8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59;  8'h1A: ascii = 8'h5A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            default: ascii = 8'h00;
        endcase
    end
endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 key sequencer: pops receiver bytes, tracks E0/F0 prefixes and held-key state, and emits
// one key event per complete code. Define PS2_KEY_CTRL_REPEAT_EVT_EN to emit typematic repeats.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned COUNT_W     = 8,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               clr,
    ps2_key_ctrl_if.master     bus,
    output logic               key_down,
    output logic [7:0]         cur_scan,
    output logic [COUNT_W-1:0] press_count,
    output logic               prefix_err
);

`ifdef PS2_KEY_CTRL_REPEAT_EVT_EN
    localparam bit REPEAT_EVT = 1'b1;
`else
    localparam bit REPEAT_EVT = 1'b0;
`endif

    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e         state_q;
    logic [TMO_W-1:0] tmo_q;
    logic           evt_valid_q;
    logic [7:0]     evt_scan_q;
    logic [7:0]     evt_ascii_q;
    logic           evt_release_q;
    logic           evt_ext_q;

    logic [7:0] byte_in;
    logic [7:0] lut_ascii;
    logic       is_prefix, is_ign, is_term;
    logic       st_ext, st_brk;
    logic       is_repeat, silent_drop, slot_free;
    logic       pop, load;

    scan_ascii u_scan_ascii (
        .scan  (byte_in),
        .ascii (lut_ascii)
    );

    always_comb begin
        byte_in     = bus.in_data;
        is_prefix   = (byte_in == SC_EXT) || (byte_in == SC_BRK);
        is_ign      = is_ignored(byte_in);
        is_term     = !is_prefix && !is_ign;
        st_ext      = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        st_brk      = (state_q == S_BRK) || (state_q == S_EXT_BRK);
        is_repeat   = !st_brk && key_down && (byte_in == cur_scan);
        // Silent repeats need no slot, so they never stall the FIFO.
        silent_drop = is_repeat && !REPEAT_EVT;
        slot_free   = !evt_valid_q || bus.evt_ready;
        pop         = bus.in_valid && (!is_term || slot_free || silent_drop);
        load        = pop && is_term && !silent_drop;
    end

    assign bus.in_pop      = pop;
    assign bus.evt_valid   = evt_valid_q;
    assign bus.evt_scan    = evt_scan_q;
    assign bus.evt_ascii   = evt_ascii_q;
    assign bus.evt_release = evt_release_q;
    assign bus.evt_ext     = evt_ext_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= S_IDLE;
            tmo_q         <= '0;
            evt_valid_q   <= 1'b0;
            evt_scan_q    <= 8'h00;
            evt_ascii_q   <= 8'h00;
            evt_release_q <= 1'b0;
            evt_ext_q     <= 1'b0;
            key_down      <= 1'b0;
            cur_scan      <= 8'h00;
            press_count   <= '0;
            prefix_err    <= 1'b0;
        end else begin
            if (pop || state_q == S_IDLE) begin
                tmo_q <= '0;
            end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                tmo_q      <= '0;
                state_q    <= S_IDLE;
                prefix_err <= 1'b1;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (pop) begin
                if (byte_in == SC_EXT) begin
                    state_q <= st_brk ? S_EXT_BRK : S_EXT;
                end else if (byte_in == SC_BRK) begin
                    state_q <= st_ext ? S_EXT_BRK : S_BRK;
                end else if (is_term) begin
                    state_q <= S_IDLE;
                    if (st_brk) begin
                        // Releasing a rolled-over key leaves the held key untouched.
                        if (byte_in == cur_scan) key_down <= 1'b0;
                    end else if (!is_repeat) begin
                        key_down    <= 1'b1;
                        cur_scan    <= byte_in;
                        press_count <= press_count + 1'b1;
                    end
                end
            end

            if (load) begin
                evt_valid_q   <= 1'b1;
                evt_scan_q    <= byte_in;
                evt_ascii_q   <= st_ext ? 8'h00 : lut_ascii;
                evt_release_q <= st_brk;
                evt_ext_q     <= st_ext;
            end else if (bus.evt_ready) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a byte-stream reference model predicts events and key
// state, a FIFO model feeds the DUT, and a monitor checks every handshaked event.
module tb_ps2_key_ctrl;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned TMO     = 16;

`ifdef PS2_KEY_CTRL_REPEAT_EVT_EN
    bit rep_en = 1'b1;
`else
    bit rep_en = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    ps2_key_ctrl_if bus ();
    logic               key_down;
    logic [7:0]         cur_scan;
    logic [COUNT_W-1:0] press_count;
    logic               prefix_err;

    ps2_key_ctrl #(
        .COUNT_W     (COUNT_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .bus         (bus),
        .key_down    (key_down),
        .cur_scan    (cur_scan),
        .press_count (press_count),
        .prefix_err  (prefix_err)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  rx_q[$];
    logic [17:0] exp_q[$];

    bit          m_ext = 0, m_brk = 0, m_down = 0, m_err = 0;
    logic [7:0]  m_cur = 8'h00;
    int unsigned m_cnt = 0;

    bit   rand_ready  = 0;
    logic ready_fixed = 1'b1;

    logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46};
    logic [7:0] pool   [16] = '{8'h1C, 8'h32, 8'h21, 8'h16, 8'h1E, 8'h75, 8'h1A, 8'hE0, 8'hF0,
                                8'hF0, 8'hAA, 8'h00, 8'hFA, 8'h1C, 8'h32, 8'h1C};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_ascii(input logic [7:0] sc);
        for (int i = 0; i < 26; i++) if (sc == let_sc[i]) return 8'(8'h41 + i);
        for (int i = 0; i < 10; i++) if (sc == dig_sc[i]) return 8'(8'h30 + i);
        return 8'h00;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        bit emit;
        bit rel;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFF, 8'hE1})) begin
            emit = 1;
            rel  = m_brk;
            if (m_brk) begin
                if (b == m_cur) m_down = 0;
            end else if (m_down && b == m_cur) begin
                emit = rep_en;
            end else begin
                m_down = 1;
                m_cur  = b;
                m_cnt++;
            end
            if (emit) exp_q.push_back({b, (m_ext ? 8'h00 : ref_ascii(b)), rel, m_ext});
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_timeout();
        if (m_ext || m_brk) m_err = 1;
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic send(input logic [7:0] b);
        model_byte(b);
        rx_q.push_back(b);
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (rx_q.size() == 0 && exp_q.size() == 0 && !bus.evt_valid) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got fifo=%0d pending=%0d want 0 0", rx_q.size(),
                     exp_q.size());
        end
    endtask

    task automatic status(input string tag);
        @(negedge clk);
        check({tag, "_key_down"}, 32'(key_down), 32'(m_down));
        check({tag, "_cur_scan"}, 32'(cur_scan), 32'(m_cur));
        check({tag, "_press_count"}, 32'(press_count), 32'(m_cnt[COUNT_W-1:0]));
        check({tag, "_prefix_err"}, 32'(prefix_err), 32'(m_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_evt_valid"}, 32'(bus.evt_valid), 32'd0);
        check({tag, "_evt_fields"}, 32'({bus.evt_scan, bus.evt_ascii, bus.evt_release,
                                         bus.evt_ext}), 32'd0);
        check({tag, "_status"}, 32'({key_down, cur_scan, press_count, prefix_err}), 32'd0);
    endtask

    // Receiver FIFO model: the pop decision is sampled mid-cycle and applied after the edge.
    initial begin : feed
        logic popped;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.evt_ready = 1'b1;
        forever begin
            @(negedge clk);
            popped = bus.in_valid && bus.in_pop;
            @(posedge clk);
            #1;
            if (popped && rx_q.size() > 0) void'(rx_q.pop_front());
            bus.in_valid  = (rx_q.size() > 0);
            bus.in_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            bus.evt_ready = rand_ready ? ($urandom_range(3) != 0) : ready_fixed;
        end
    end

    initial begin : monitor
        logic [17:0] got;
        forever begin
            @(negedge clk);
            if (!clr && bus.evt_valid && bus.evt_ready) begin
                got = {bus.evt_scan, bus.evt_ascii, bus.evt_release, bus.evt_ext};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_evt: got %0h want none", got);
                end else begin
                    check("evt", 32'(got), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 clr = 1'b0;

        send(8'h1C); send(8'hF0); send(8'h1C);
        drain(200);
        status("make_break");

        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        drain(200);
        status("typematic");

        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain(200);
        status("extended");

        send(8'h32); send(8'h21); send(8'hF0); send(8'h32);
        drain(200);
        status("rollover");
        send(8'hF0); send(8'h21);
        drain(200);

        ready_fixed = 1'b0;
        send(8'h16); send(8'h1E);
        repeat (8) @(negedge clk);
        check("bp_in_pop", 32'(bus.in_pop), 32'd0);
        check("bp_fifo_depth", 32'(rx_q.size()), 32'd1);
        check("bp_evt_held", 32'({bus.evt_valid, bus.evt_ascii}), 32'h131);
        ready_fixed = 1'b1;
        drain(200);
        status("backpressure");

        send(8'hF0);
        drain(200);
        repeat (3 * TMO) @(negedge clk);
        model_timeout();
        status("timeout");
        send(8'h1C);
        drain(200);
        status("after_timeout");

        rand_ready = 1;
        for (int i = 0; i < 300; i++) send(pool[$urandom_range(15)]);
        drain(5000);
        rand_ready = 0;
        repeat (3 * TMO) @(negedge clk);
        model_timeout();
        status("random");

        send(8'hF0);
        drain(200);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 clr = 1'b1;
        m_ext = 0; m_brk = 0; m_down = 0; m_err = 0; m_cur = 8'h00; m_cnt = 0;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk);
        #1 clr = 1'b0;
        send(8'h1C);
        drain(200);
        status("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
